shift_register_bidirectional: RTL and testbench



---
 rtl/shift_register_bidirectional_pkg.sv | 13 +
 rtl/shift_register_bidirectional.sv | 70 +++++++
 tb/tb_shift_register_bidirectional.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_bidirectional_pkg.sv
// Shared constants for the digit shift register and the display controller
// that drives it: default digit geometry and the shift-direction encoding.
package shift_register_bidirectional_pkg;

    localparam int DIGIT_BITS    = 4;
    localparam int NUM_DIGITS    = 5;
    localparam int DEFAULT_WIDTH = DIGIT_BITS * NUM_DIGITS;

    // Direction encoding for the dir input
    localparam logic DIR_LEFT  = 1'b0;  // toward MSB
    localparam logic DIR_RIGHT = 1'b1;  // toward LSB

endpackage : shift_register_bidirectional_pkg

// File: rtl/shift_register_bidirectional.sv
// Parallel-load shift register that moves its contents one digit (STEP bits)
// left or right per enabled clock, either zero-filling or rotating.
// Priority per edge: rst > load > en > hold. out is the register itself.
module shift_register_bidirectional
    import shift_register_bidirectional_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP   = DIGIT_BITS,
    parameter bit ROTATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] out
);

    // Geometry guard: whole digits only, and at least two digits
    if ((WIDTH % STEP) != 0 || STEP >= WIDTH) begin : g_bad_geometry
        $error("shift_register_bidirectional: WIDTH must be a multiple of STEP and STEP < WIDTH");
    end

    logic [WIDTH-1:0] reg_r;
    logic [WIDTH-1:0] next_s;
    logic [STEP-1:0]  fill_left_s;   // digit entering at the LSB end on a left shift
    logic [STEP-1:0]  fill_right_s;  // digit entering at the MSB end on a right shift

    // Select the digit that refills the vacated end: zeros, or the digit shifted out
    always_comb begin
        fill_left_s  = {STEP{1'b0}};
        fill_right_s = {STEP{1'b0}};
        if (ROTATE) begin
            fill_left_s  = reg_r[WIDTH-1 -: STEP];
            fill_right_s = reg_r[STEP-1:0];
        end else begin
            fill_left_s  = {STEP{1'b0}};
            fill_right_s = {STEP{1'b0}};
        end
    end

    // Next-state selection: load beats shift, shift beats hold
    always_comb begin
        next_s = reg_r;
        if (load) begin
            next_s = num;
        end else if (en) begin
            case (dir)
                DIR_LEFT:  next_s = {reg_r[WIDTH-STEP-1:0], fill_left_s};
                DIR_RIGHT: next_s = {fill_right_s, reg_r[WIDTH-1:STEP]};
                default:   next_s = reg_r;
            endcase
        end else begin
            next_s = reg_r;
        end
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_r <= {WIDTH{1'b0}};
        end else begin
            reg_r <= next_s;
        end
    end

    assign out = reg_r;

endmodule : shift_register_bidirectional

// File: tb/tb_shift_register_bidirectional.sv
// Directed bench: one zero-fill instance and one rotating instance share the
// same stimulus; every expected value is a hand-computed constant.
module tb_shift_register_bidirectional;

    localparam int W = 20;

    logic         clk;
    logic         rst;
    logic         en;
    logic         dir;
    logic         load;
    logic [W-1:0] num;
    logic [W-1:0] out0;  // ROTATE = 0
    logic [W-1:0] out1;  // ROTATE = 1

    int n_checks;
    int n_pass;

    shift_register_bidirectional #(.WIDTH(W), .STEP(4), .ROTATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .num(num), .out(out0)
    );

    shift_register_bidirectional #(.WIDTH(W), .STEP(4), .ROTATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .num(num), .out(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle #1 past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        en   = 1'b0;
        num  = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; num = 20'h12345; load = 1'b0; en = 1'b0; dir = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out0 !== 20'h00000) $display("FAIL reset_r0 got %h want %h", out0, 20'h00000);
        else n_pass++;
        n_checks++;
        if (out1 !== 20'h00000) $display("FAIL reset_r1 got %h want %h", out1, 20'h00000);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (out0 !== 20'h00000 || out1 !== 20'h00000)
                $display("FAIL reset_idle cycle %0d got %h/%h want 00000", i, out0, out1);
            else n_pass++;
        end
    endtask

    task automatic test_load();
        do_load(20'h12345);
        n_checks++;
        if (out0 !== 20'h12345 || out1 !== 20'h12345)
            $display("FAIL load got %h/%h want 12345", out0, out1);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out0 !== 20'h12345 || out1 !== 20'h12345)
                $display("FAIL load_hold cycle %0d got %h/%h want 12345", i, out0, out1);
            else n_pass++;
        end
    endtask

    task automatic test_single_shift();
        do_load(20'h12345);
        en = 1'b1; dir = 1'b0;
        tick();
        en = 1'b0;
        n_checks++;
        if (out0 !== 20'h23450) $display("FAIL shl1_r0 got %h want %h", out0, 20'h23450);
        else n_pass++;
        n_checks++;
        if (out1 !== 20'h23451) $display("FAIL shl1_r1 got %h want %h", out1, 20'h23451);
        else n_pass++;
        do_load(20'h12345);
        en = 1'b1; dir = 1'b1;
        tick();
        en = 1'b0;
        n_checks++;
        if (out0 !== 20'h01234) $display("FAIL shr1_r0 got %h want %h", out0, 20'h01234);
        else n_pass++;
        n_checks++;
        if (out1 !== 20'h51234) $display("FAIL shr1_r1 got %h want %h", out1, 20'h51234);
        else n_pass++;
    endtask

    task automatic test_held_enable();
        logic [W-1:0] exp0 [6];
        logic [W-1:0] exp1 [6];
        logic [W-1:0] expr [5];
        exp0 = '{20'h23450, 20'h34500, 20'h45000, 20'h50000, 20'h00000, 20'h00000};
        exp1 = '{20'h23451, 20'h34512, 20'h45123, 20'h51234, 20'h12345, 20'h23451};
        expr = '{20'h51234, 20'h45123, 20'h34512, 20'h23451, 20'h12345};
        do_load(20'h12345);
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (out0 !== exp0[i] || out1 !== exp1[i])
                $display("FAIL held_left step %0d got %h/%h want %h/%h", i, out0, out1, exp0[i], exp1[i]);
            else n_pass++;
        end
        en = 1'b0;
        do_load(20'h12345);
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out1 !== expr[i])
                $display("FAIL held_right_rot step %0d got %h want %h", i, out1, expr[i]);
            else n_pass++;
        end
        n_checks++;
        if (out0 !== 20'h00000) $display("FAIL held_right_zero got %h want %h", out0, 20'h00000);
        else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_dir_change();
        do_load(20'h12345);
        en = 1'b1; dir = 1'b0;
        tick();
        dir = 1'b1;
        tick();
        en = 1'b0;
        n_checks++;
        if (out0 !== 20'h02345) $display("FAIL dirchg_r0 got %h want %h", out0, 20'h02345);
        else n_pass++;
        n_checks++;
        if (out1 !== 20'h12345) $display("FAIL dirchg_r1 got %h want %h", out1, 20'h12345);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_load(20'h12345);
        load = 1'b1; en = 1'b1; dir = 1'b0; num = 20'hABCDE;
        tick();
        n_checks++;
        if (out0 !== 20'hABCDE || out1 !== 20'hABCDE)
            $display("FAIL load_over_en got %h/%h want ABCDE", out0, out1);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        n_checks++;
        if (out0 !== 20'h00000 || out1 !== 20'h00000)
            $display("FAIL rst_over_load got %h/%h want 00000", out0, out1);
        else n_pass++;
        // A reset pulse that ends before the next edge must be ignored
        do_load(20'h13579);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        n_checks++;
        if (out0 !== 20'h13579 || out1 !== 20'h13579)
            $display("FAIL rst_glitch got %h/%h want 13579", out0, out1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_load(20'h12345);
        en = 1'b1; dir = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out0 !== 20'h34500) $display("FAIL mid_pre got %h want %h", out0, 20'h34500);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out0 !== 20'h00000 || out1 !== 20'h00000)
            $display("FAIL mid_rst got %h/%h want 00000", out0, out1);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out0 !== 20'h00000 || out1 !== 20'h00000)
                $display("FAIL mid_resume cycle %0d got %h/%h want 00000", i, out0, out1);
            else n_pass++;
        end
        en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; num = '0;
        test_reset();
        test_load();
        test_single_shift();
        test_held_enable();
        test_dir_change();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_register_bidirectional
